// File: rtl/uart_reg_writer_if.sv
// Register-write bus between the UART frame parser and a peripheral.
// A write transfers when wr_valid and wr_ready are both high on a clock edge.
interface uart_reg_writer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_reg_writer.sv
// Parses framed UART writes (sync, address, data, optional XOR checksum) into
// register writes on a valid/ready bus, with inter-byte timeout and error counters.
module uart_reg_writer #(
  parameter int unsigned       CLK_FREQ     = 12_000_000,
  parameter int unsigned       ADDR_BYTES   = 1,
  parameter int unsigned       DATA_BYTES   = 1,
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] ADDR_BASE    = 16'hFF00,
  parameter logic [7:0]        SYNC_BYTE    = 8'hA5,
  parameter bit                USE_CHECKSUM = 1'b1,
  parameter int unsigned       TIMEOUT_US   = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_received,
  uart_reg_writer_if.master wr,
  output logic              busy,
  output logic [7:0]        err_count,
  output logic [1:0]        last_err
);

  localparam int unsigned AddrSw        = 8 * ADDR_BYTES;
  localparam int unsigned DataW         = 8 * DATA_BYTES;
  localparam int unsigned TimeoutCycles = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam logic [1:0]  LastAddrIdx   = 2'(ADDR_BYTES - 1);
  localparam logic [1:0]  LastDataIdx   = 2'(DATA_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StCsum} state_e;

  state_e              state_q, state_d;
  logic [1:0]          idx_q;
  logic [7:0]          xor_q;
  logic [AddrSw-1:0]   addr_sh_q, addr_shift;
  logic [DataW-1:0]    data_sh_q, data_shift, commit_data;
  logic [AddrSw+7:0]   addr_cat;
  logic [DataW+7:0]    data_cat;
  logic [31:0]         cnt_q;
  logic                valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DataW-1:0]    data_q;
  logic                commit, csum_err, timeout, accept, overrun, err;
  logic [1:0]          err_code;
  logic [1:0]          rst_sync_q;
  logic                rst_n_int;

  // Asynchronous assertion, release synchronised to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  always_comb begin
    addr_cat    = {addr_sh_q, rx_data};
    data_cat    = {data_sh_q, rx_data};
    addr_shift  = addr_cat[AddrSw-1:0];
    data_shift  = data_cat[DataW-1:0];
    commit_data = (state_q == StCsum) ? data_sh_q : data_shift;
    commit      = rx_received &&
                  ((state_q == StData && idx_q == LastDataIdx && !USE_CHECKSUM) ||
                   (state_q == StCsum && rx_data == xor_q));
    csum_err    = rx_received && state_q == StCsum && rx_data != xor_q;
    timeout     = !rx_received && state_q != StIdle && cnt_q >= TimeoutCycles;
    accept      = valid_q && wr.wr_ready;
    overrun     = commit && valid_q && !accept;
    err         = csum_err || timeout || overrun;
    err_code    = 2'd0;
    if (csum_err)     err_code = 2'd1;
    else if (timeout) err_code = 2'd2;
    else if (overrun) err_code = 2'd3;

    state_d = state_q;
    unique case (state_q)
      StIdle: if (rx_received && rx_data == SYNC_BYTE) state_d = StAddr;
      StAddr: if (rx_received && idx_q == LastAddrIdx) state_d = StData;
      StData: if (rx_received && idx_q == LastDataIdx) state_d = USE_CHECKSUM ? StCsum : StIdle;
      StCsum: if (rx_received) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (timeout) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      xor_q     <= 8'd0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      cnt_q     <= 32'd0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy      <= 1'b0;
      err_count <= 8'd0;
      last_err  <= 2'd0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != StIdle);
      cnt_q   <= (state_q == StIdle || rx_received) ? 32'd0 : cnt_q + 32'd1;

      if (rx_received) begin
        unique case (state_q)
          StIdle: begin
            idx_q <= 2'd0;
            xor_q <= 8'd0;
          end
          StAddr: begin
            addr_sh_q <= addr_shift;
            xor_q     <= xor_q ^ rx_data;
            idx_q     <= (idx_q == LastAddrIdx) ? 2'd0 : idx_q + 2'd1;
          end
          StData: begin
            data_sh_q <= data_shift;
            xor_q     <= xor_q ^ rx_data;
            idx_q     <= (idx_q == LastDataIdx) ? 2'd0 : idx_q + 2'd1;
          end
          StCsum: idx_q <= 2'd0;
          default: idx_q <= 2'd0;
        endcase
      end

      if (timeout) begin
        addr_sh_q <= '0;
        data_sh_q <= '0;
        idx_q     <= 2'd0;
        xor_q     <= 8'd0;
      end

      // A commit in the accept cycle refills the slot, keeping wr_valid high.
      if (commit && !overrun) begin
        valid_q <= 1'b1;
        addr_q  <= ADDR_BASE | ADDR_W'(addr_sh_q);
        data_q  <= commit_data;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (err) begin
        last_err <= err_code;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  assign wr.wr_valid = valid_q;
  assign wr.wr_addr  = addr_q;
  assign wr.wr_data  = data_q;

endmodule
